// File: rtl/sevenseg_mux_driver.sv
// sevenseg_mux_driver
//   Time-multiplexed hex seven-segment driver. NUM_DIGITS displays share one
//   segment bus. A prescaler holds each digit for REFRESH_DIV clocks.
//   Loaded data is staged in a pending buffer and only moves into the
//   displayed (shadow) buffer at a frame wrap, so a frame never tears.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   enable       1 = scan; 0 = freeze counters, outputs driven low
//   load         single-cycle strobe, captures value/dp_in
//   value        packed hex nibbles, nibble k -> digit k
//   dp_in        per-digit decimal point
//   blank_zeros  blank leading zero digits (digit 0 never blanked)
//   seg          {dp, G..A}, active-high, registered
//   an           one-hot digit select, active-high, registered
//   frame_done   one-cycle pulse on each frame wrap
module sevenseg_mux_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic                      blank_zeros,
    output logic [7:0]                seg,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      frame_done
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]          pre_cnt_q, pre_cnt_d;
    logic [IDX_W-1:0]          dig_idx_q, dig_idx_d;
    logic [4*NUM_DIGITS-1:0]   pending_q, pending_d;
    logic [NUM_DIGITS-1:0]     pending_dp_q, pending_dp_d;
    logic [4*NUM_DIGITS-1:0]   shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0]     shadow_dp_q, shadow_dp_d;
    logic                      pend_flag_q, pend_flag_d;
    logic [7:0]                seg_q, seg_d;
    logic [NUM_DIGITS-1:0]     an_q, an_d;
    logic                      frame_done_q, frame_done_d;

    logic                      tc;
    logic                      wrap;
    logic [3:0]                cur_nib;
    logic [NUM_DIGITS-1:0]     lead_zero;
    logic                      all_zero;

    function automatic logic [6:0] glyph(input logic [3:0] nib);
        case (nib)
            4'h0: glyph = 7'h3F;
            4'h1: glyph = 7'h06;
            4'h2: glyph = 7'h5B;
            4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66;
            4'h5: glyph = 7'h6D;
            4'h6: glyph = 7'h7D;
            4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F;
            4'h9: glyph = 7'h6F;
            4'hA: glyph = 7'h77;
            4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39;
            4'hD: glyph = 7'h5E;
            4'hE: glyph = 7'h79;
            default: glyph = 7'h71;
        endcase
    endfunction

    // Digit k is a leading zero when every nibble from the top down to k is 0.
    always_comb begin
        lead_zero = '0;
        all_zero  = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            all_zero     = all_zero & (shadow_q[4*k +: 4] == 4'h0);
            lead_zero[k] = all_zero;
        end
    end

    assign tc      = enable && (pre_cnt_q == CNT_LAST);
    assign wrap    = tc && (dig_idx_q == IDX_LAST);
    assign cur_nib = shadow_q[{dig_idx_q, 2'b00} +: 4];

    always_comb begin
        pre_cnt_d    = pre_cnt_q;
        dig_idx_d    = dig_idx_q;
        pending_d    = pending_q;
        pending_dp_d = pending_dp_q;
        shadow_d     = shadow_q;
        shadow_dp_d  = shadow_dp_q;
        pend_flag_d  = pend_flag_q;

        if (enable) begin
            pre_cnt_d = tc ? '0 : pre_cnt_q + CNT_W'(1);
        end
        if (tc) begin
            dig_idx_d = wrap ? '0 : dig_idx_q + IDX_W'(1);
        end

        // A load landing on the wrap edge bypasses pending and shows at once.
        if (wrap) begin
            if (load) begin
                shadow_d    = value;
                shadow_dp_d = dp_in;
            end else if (pend_flag_q) begin
                shadow_d    = pending_q;
                shadow_dp_d = pending_dp_q;
            end
            pend_flag_d = 1'b0;
        end else if (load) begin
            pending_d    = value;
            pending_dp_d = dp_in;
            pend_flag_d  = 1'b1;
        end

        seg_d        = 8'h00;
        an_d         = '0;
        frame_done_d = wrap;
        if (enable) begin
            seg_d[7]   = shadow_dp_q[dig_idx_q];
            seg_d[6:0] = (blank_zeros && lead_zero[dig_idx_q]) ? 7'h00 : glyph(cur_nib);
            an_d       = NUM_DIGITS'(1) << dig_idx_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt_q    <= '0;
            dig_idx_q    <= '0;
            pending_q    <= '0;
            pending_dp_q <= '0;
            shadow_q     <= '0;
            shadow_dp_q  <= '0;
            pend_flag_q  <= 1'b0;
            seg_q        <= 8'h00;
            an_q         <= '0;
            frame_done_q <= 1'b0;
        end else begin
            pre_cnt_q    <= pre_cnt_d;
            dig_idx_q    <= dig_idx_d;
            pending_q    <= pending_d;
            pending_dp_q <= pending_dp_d;
            shadow_q     <= shadow_d;
            shadow_dp_q  <= shadow_dp_d;
            pend_flag_q  <= pend_flag_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule
